// File: rtl/serial_word_receiver.sv
// serial_word_receiver: serial-in / parallel-out far end of the 4-bit shift-register link.
// Assembles WIDTH-bit words MSB-first or LSB-first from a gated bit stream and presents
// them on a registered output with a VALID/RDY handshake and a sticky overrun flag.
// Optional build macro SERIAL_RX_PARITY_EN: appends one even-parity bit per frame and
// reports a mismatch on PERR alongside the word on Q.
module serial_word_receiver #(
    parameter int WIDTH = 4
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             SI,
    input  logic             SEN,
    input  logic             DIR,
    input  logic             RDY,
    input  logic             OVR_CLR,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             BUSY,
    output logic             OVR,
    output logic             PERR
);

`ifdef SERIAL_RX_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam int CNT_W = $clog2(FL + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             dir_l;
    logic             dir_next;
    logic             sample_dir;
    logic             done;
    logic             accept;
    logic             overrun;

    // State register: FSM state, bit counter, shift register and latched direction
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            dir_l <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sr    <= sr_next;
            dir_l <= dir_next;
        end
    end

    // Next-state logic: sample a bit on each strobe, finish the frame on bit FL
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sr_next    = sr;
        dir_next   = dir_l;
        done       = 1'b0;
        // The first bit of a frame uses the live DIR; later bits use the latched copy
        sample_dir = (state == IDLE) ? DIR : dir_l;
        shifted    = sample_dir ? {sr[WIDTH-2:0], SI} : {SI, sr[WIDTH-1:1]};
        cnt_inc    = cnt + CNT_W'(1);
`ifdef SERIAL_RX_PARITY_EN
        // The completing bit is the parity bit, so the data word is already in SR
        word       = sr;
`else
        word       = shifted;
`endif
        if (SEN) begin
            if (state == IDLE) begin
                dir_next = DIR;
            end
`ifdef SERIAL_RX_PARITY_EN
            if (cnt != CNT_W'(WIDTH)) begin
                sr_next = shifted;
            end
`else
            sr_next = shifted;
`endif
            if (cnt_inc == CNT_W'(FL)) begin
                done       = 1'b1;
                state_next = IDLE;
                cnt_next   = '0;
            end else begin
                state_next = SHIFT;
                cnt_next   = cnt_inc;
            end
        end
    end

    // Output decode: busy flag and what happens to a completed word
    always_comb begin
        BUSY    = (state == SHIFT);
        accept  = done && (!VALID || RDY);
        overrun = done && VALID && !RDY;
    end

    // Output word register, handshake and sticky overrun (set wins over clear)
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            Q     <= '0;
            VALID <= 1'b0;
            OVR   <= 1'b0;
        end else begin
            if (accept) begin
                Q     <= word;
                VALID <= 1'b1;
            end else if (VALID && RDY) begin
                VALID <= 1'b0;
            end
            if (overrun) begin
                OVR <= 1'b1;
            end else if (OVR_CLR) begin
                OVR <= 1'b0;
            end
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    logic perr_q;

    // Parity result travels with the accepted word; dropped words leave it alone
    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            perr_q <= 1'b0;
        end else if (accept) begin
            perr_q <= (^sr) ^ SI;
        end
    end

    assign PERR = perr_q;
`else
    assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver (WIDTH=4) with a word scoreboard.
module tb_serial_word_receiver;
    localparam int W = 4;

    logic         CP = 1'b0;
    logic         CR = 1'b0;
    logic         SI = 1'b0;
    logic         SEN = 1'b0;
    logic         DIR = 1'b0;
    logic         RDY = 1'b0;
    logic         OVR_CLR = 1'b0;
    logic [W-1:0] Q;
    logic         VALID;
    logic         BUSY;
    logic         OVR;
    logic         PERR;

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] exp_w;
    logic [W-1:0] held_w;

    serial_word_receiver #(.WIDTH(W)) dut (
        .CP(CP), .CR(CR), .SI(SI), .SEN(SEN), .DIR(DIR), .RDY(RDY), .OVR_CLR(OVR_CLR),
        .Q(Q), .VALID(VALID), .BUSY(BUSY), .OVR(OVR), .PERR(PERR)
    );

    always #5 CP = ~CP;

    // Sequence is written in transmission order (bit W-1 sent first).
    // MSB-first: first bit ends up in the MSB, so the word equals the sequence.
    // LSB-first: first bit ends up in bit 0, so the word is the sequence reversed.
    function automatic logic [W-1:0] expect_word(input logic [W-1:0] seq, input logic dir_v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = seq[W-1-i];
        return dir_v ? seq : r;
    endfunction

    task automatic send_bit(input logic b);
        SI  = b;
        SEN = 1'b1;
        @(posedge CP);
        #1;
        SEN = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] seq, input logic dir_v, input logic rdy_last);
        DIR = dir_v;
        RDY = 1'b0;
        sb.push_back(expect_word(seq, dir_v));
        for (int i = W - 1; i >= 0; i--) begin
`ifndef SERIAL_RX_PARITY_EN
            if (i == 0) RDY = rdy_last;
`endif
            send_bit(seq[i]);
        end
`ifdef SERIAL_RX_PARITY_EN
        RDY = rdy_last;
        send_bit(^seq);
`endif
        RDY = 1'b0;
    endtask

    task automatic consume();
        RDY = 1'b1;
        @(posedge CP);
        #1;
        RDY = 1'b0;
    endtask

    task automatic test_reset();
        CR = 1'b0;
        repeat (2) @(posedge CP);
        #1;
        total++;
        if ({Q, VALID, BUSY, OVR, PERR} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0", {Q, VALID, BUSY, OVR, PERR});
        end
        CR = 1'b1;
        @(posedge CP);
        #1;
        total++;
        if (VALID !== 1'b0 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got valid=%b busy=%b want 0 0", VALID, BUSY);
        end
    endtask

    task automatic test_msb_first();
        logic [W-1:0] seq;
        seq = 4'b1011;
        RDY = 1'b0;
        DIR = 1'b1;
        sb.push_back(expect_word(seq, 1'b1));
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(seq[i]);
            if (i > 0) begin
                total++;
                if (BUSY !== 1'b1 || VALID !== 1'b0) begin
                    bad++;
                    $display("FAIL msb_busy bit%0d: got busy=%b valid=%b want 1 0", W - i, BUSY, VALID);
                end
            end
        end
`ifdef SERIAL_RX_PARITY_EN
        send_bit(^seq);
`endif
        exp_w = sb.pop_front();
        total++;
        if (VALID !== 1'b1 || Q !== exp_w || Q !== 4'b1011) begin
            bad++;
            $display("FAIL msb_word: got valid=%b q=%b want 1 %b", VALID, Q, exp_w);
        end
        total++;
        if (BUSY !== 1'b0) begin
            bad++;
            $display("FAIL msb_busy_end: got %b want 0", BUSY);
        end
        consume();
        total++;
        if (VALID !== 1'b0) begin
            bad++;
            $display("FAIL msb_consume: got valid=%b want 0", VALID);
        end
    endtask

    task automatic test_lsb_gaps();
        logic [W-1:0] seq;
        seq = 4'b1011;
        RDY = 1'b0;
        DIR = 1'b0;
        sb.push_back(expect_word(seq, 1'b0));
        send_bit(seq[3]);
        send_bit(seq[2]);
        DIR = 1'b1;
        repeat (3) @(posedge CP);
        #1;
        total++;
        if (BUSY !== 1'b1 || VALID !== 1'b0) begin
            bad++;
            $display("FAIL lsb_gap_hold: got busy=%b valid=%b want 1 0", BUSY, VALID);
        end
        send_bit(seq[1]);
        DIR = 1'b0;
        send_bit(seq[0]);
`ifdef SERIAL_RX_PARITY_EN
        DIR = 1'b1;
        send_bit(^seq);
`endif
        exp_w = sb.pop_front();
        total++;
        if (VALID !== 1'b1 || Q !== exp_w || Q !== 4'b1101) begin
            bad++;
            $display("FAIL lsb_word: got valid=%b q=%b want 1 %b", VALID, Q, exp_w);
        end
        consume();
    endtask

    task automatic test_overrun();
        send_word(4'b0011, 1'b1, 1'b0);
        exp_w = sb.pop_front();
        held_w = exp_w;
        total++;
        if (VALID !== 1'b1 || Q !== exp_w) begin
            bad++;
            $display("FAIL ovr_first: got valid=%b q=%b want 1 %b", VALID, Q, exp_w);
        end
        send_word(4'b1110, 1'b1, 1'b0);
        exp_w = sb.pop_front();
        total++;
        if (Q !== held_w || VALID !== 1'b1 || OVR !== 1'b1) begin
            bad++;
            $display("FAIL ovr_drop: got q=%b valid=%b ovr=%b want %b 1 1 (dropped %b)", Q, VALID, OVR, held_w, exp_w);
        end
        consume();
        total++;
        if (VALID !== 1'b0 || OVR !== 1'b1) begin
            bad++;
            $display("FAIL ovr_sticky: got valid=%b ovr=%b want 0 1", VALID, OVR);
        end
        OVR_CLR = 1'b1;
        @(posedge CP);
        #1;
        OVR_CLR = 1'b0;
        total++;
        if (OVR !== 1'b0) begin
            bad++;
            $display("FAIL ovr_clear: got %b want 0", OVR);
        end
    endtask

    task automatic test_simultaneous();
        send_word(4'b0101, 1'b1, 1'b0);
        exp_w = sb.pop_front();
        total++;
        if (VALID !== 1'b1 || Q !== exp_w) begin
            bad++;
            $display("FAIL simul_first: got valid=%b q=%b want 1 %b", VALID, Q, exp_w);
        end
        send_word(4'b1001, 1'b1, 1'b1);
        exp_w = sb.pop_front();
        total++;
        if (VALID !== 1'b1 || Q !== exp_w || OVR !== 1'b0) begin
            bad++;
            $display("FAIL simul_replace: got valid=%b q=%b ovr=%b want 1 %b 0", VALID, Q, OVR, exp_w);
        end
        consume();
    endtask

    task automatic test_midframe_reset();
        DIR = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        CR = 1'b0;
        #2;
        total++;
        if ({Q, VALID, BUSY, OVR, PERR} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got %b want 0", {Q, VALID, BUSY, OVR, PERR});
        end
        @(posedge CP);
        #1;
        CR = 1'b1;
        send_word(4'b0110, 1'b1, 1'b0);
        exp_w = sb.pop_front();
        total++;
        if (VALID !== 1'b1 || Q !== exp_w || Q !== 4'b0110) begin
            bad++;
            $display("FAIL midreset_word: got valid=%b q=%b want 1 %b", VALID, Q, exp_w);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w;
        logic         d;
        for (int k = 0; k < 6; k++) begin
            w = W'($urandom_range(0, (1 << W) - 1));
            d = 1'($urandom_range(0, 1));
            send_word(w, d, 1'b1);
            exp_w = sb.pop_front();
            total++;
            if (VALID !== 1'b1 || Q !== exp_w || BUSY !== 1'b0 || OVR !== 1'b0) begin
                bad++;
                $display("FAIL b2b_word%0d: got valid=%b q=%b busy=%b ovr=%b want 1 %b 0 0", k, VALID, Q, BUSY, OVR, exp_w);
            end
        end
        consume();
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] seq;
        seq = 4'b1011;
        for (int p = 1; p >= 0; p--) begin
            DIR = 1'b1;
            RDY = 1'b0;
            sb.push_back(expect_word(seq, 1'b1));
            for (int i = W - 1; i >= 0; i--) send_bit(seq[i]);
            send_bit(p[0]);
            exp_w = sb.pop_front();
            total++;
            if (Q !== exp_w || VALID !== 1'b1 || PERR !== (p == 1 ? 1'b0 : 1'b1)) begin
                bad++;
                $display("FAIL parity_bit%0d: got q=%b valid=%b perr=%b want %b 1 %b", p, Q, VALID, PERR, exp_w, (p == 1 ? 1'b0 : 1'b1));
            end
            consume();
        end
    endtask
`else
    task automatic test_parity();
        send_word(4'b1000, 1'b1, 1'b0);
        exp_w = sb.pop_front();
        total++;
        if (Q !== exp_w || PERR !== 1'b0) begin
            bad++;
            $display("FAIL parity_off: got q=%b perr=%b want %b 0", Q, PERR, exp_w);
        end
        consume();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_gaps();
        test_overrun();
        test_simultaneous();
        test_midframe_reset();
        test_back_to_back();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Serial-in, parallel-out receiver that is the far end of our 4-bit universal shift-register serial link. It samples a gated serial bit stream, assembles WIDTH-bit words MSB-first or LSB-first (the two serial shift directions of the link), and presents each completed word on a registered parallel output with a VALID/RDY handshake. Overrun is flagged when a word completes while the previous one is still unconsumed. An optional parity check is available at compile time.

## Interface
- WIDTH, 4, data word width in bits; legal range is 2 to 16.
- CP  input  1  clock; all sampling is on the rising edge.
- CR  input  1  asynchronous, active-low reset.
- SI  input  1  serial data bit.
- SEN  input  1  bit strobe; SI is sampled on every rising CP edge where SEN=1.
- DIR  input  1  1 = MSB-first (each bit enters at bit 0 and shifts toward the MSB); 0 = LSB-first (each bit enters at the MSB and shifts toward bit 0).
- RDY  input  1  consumer ready.
- OVR_CLR  input  1  synchronous clear of OVR.
- Q  output  WIDTH  received word; held stable while VALID=1.
- VALID  output  1  Q holds an unconsumed word.
- BUSY  output  1  a frame is partially received.
- OVR  output  1  sticky overrun flag.
- PERR  output  1  parity error for the word currently on Q.

## Operation
- States: IDLE and SHIFT. Internal logic: shift register SR[WIDTH-1:0], bit counter CNT, and latched direction DIR_L.
- IDLE + SEN=1:
  - sample SI into SR per DIR;
  - latch DIR into DIR_L;
  - set CNT=1 and go to SHIFT (if WIDTH bits are already collected, complete immediately; this is not reachable for WIDTH≥2).
- SHIFT + SEN=1: sample SI per DIR_L and increment CNT. DIR changes mid-frame are ignored.
- SHIFT + SEN=0: hold SR and CNT. Gaps of any length are allowed.
- Shifting rules:
  - MSB-first: SR <= {SR[WIDTH-2:0], SI}.
  - LSB-first: SR <= {SI, SR[WIDTH-1:1]}.
- Frame length is FL = WIDTH, or WIDTH+1 with parity enabled. On the edge that samples bit FL the frame completes, the FSM returns to IDLE, and CNT is cleared.
- On completion:
  - If VALID=0, or VALID=1 and RDY=1 on the same edge: Q <= the assembled word and VALID stays/becomes 1.
  - If VALID=1 and RDY=0: the word is dropped, Q is unchanged, and OVR <= 1.
- Handshake: a transfer occurs on an edge with VALID=1 and RDY=1. VALID clears unless a frame completes on that same edge.
- OVR is sticky and clears only on OVR_CLR=1 or CR. If an overrun occurs and OVR_CLR=1 on the same edge, set wins.
- BUSY = (state==SHIFT), registered.

## Timing
- Reset values (CR=0, effective immediately, asynchronous): Q=0, VALID=0, BUSY=0, OVR=0, PERR=0, state=IDLE, CNT=0, SR=0.
- Reset mid-frame discards the partial frame. The first SEN=1 edge after CR deasserts starts a new frame.
- Latency: VALID and Q update on the same edge that samples the last bit, so they are visible one cycle after the last bit is presented.
- Maximum throughput is one word per FL cycles with SEN held high and RDY=1.
- A new frame may start on the edge immediately after completion, so back-to-back frames have no dead cycle.
- RDY is ignored while VALID=0.

## Configuration
- SERIAL_RX_PARITY_EN defined:
  - FL=WIDTH+1; the final bit is even parity over the data bits and is not shifted into SR.
  - On completion, PERR <= (^data) ^ parity_bit. PERR updates with Q and is held with it.
  - A dropped (overrun) word does not affect PERR.
- Not defined: FL=WIDTH, and PERR is constant 0.

## Test plan
- MSB-first: with WIDTH=4, DIR=1, SEN=1 and SI=1,0,1,1 on four edges, VALID rises after the 4th edge with Q=4'b1011 and BUSY=1 after edges 1 to 3.
- LSB-first with gaps: DIR=0 and SI=1,0,1,1, with SEN=0 for 3 cycles between bits 2 and 3; result is Q=4'b1101 and VALID=1. Toggling DIR mid-frame gives the same result.
- Overrun: with RDY=0, receive 4'b0011 then 4'b1110; Q stays 4'b0011 and OVR=1. Then RDY=1 for one edge gives VALID=0 while OVR stays 1. OVR_CLR=1 then gives OVR=0.
- Simultaneous events: the second frame completes on the same edge as RDY=1 for the first. The result is VALID=1, Q=new word, and OVR=0.
- Mid-frame reset: after 2 bits, pulse CR low. All outputs read 0, and the next 4 bits 0,1,1,0 (DIR=1) give Q=4'b0110.
- Parity (SERIAL_RX_PARITY_EN defined): 1,0,1,1 plus parity bit 1 gives Q=4'b1011 with PERR=0. The same data with parity bit 0 gives PERR=1.
